// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register file write port between writeback and loader with starvation-forced loader grants.
// Optional RF_FWD_EN adds the in-flight write bypass compare for three decode read ports.
module regfile_write_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall,
`ifdef RF_FWD_EN
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] rd_addr3,
    output logic [2:0]        fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              grant_src
);

    typedef enum logic {NORMAL, FORCE} state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              wb_xfer, ld_xfer;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // FORCE always falls back to NORMAL after one cycle, with or without a loader transfer.
    always_comb begin
        state_nxt = NORMAL;
        wait_nxt  = '0;
        wb_ready  = 1'b1;
        ld_ready  = !wb_valid;
        stall     = 1'b0;
        if (state == FORCE) begin
            wb_ready = 1'b0;
            ld_ready = 1'b1;
            stall    = 1'b1;
        end else if (ld_valid && wb_valid) begin
            if (wait_cnt == WAIT_LAST) begin
                state_nxt = FORCE;
            end else begin
                wait_nxt = wait_cnt + 1'b1;
            end
        end
    end

    assign wb_xfer = wb_valid && wb_ready;
    assign ld_xfer = ld_valid && ld_ready;

    // Register 0 is hardwired zero: the handshake completes but no write is issued.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            grant_src <= 1'b0;
        end else if (wb_xfer) begin
            rf_we     <= (wb_addr != '0);
            rf_waddr  <= wb_addr;
            rf_wdata  <= wb_data;
            grant_src <= 1'b0;
        end else if (ld_xfer) begin
            rf_we     <= (ld_addr != '0);
            rf_waddr  <= ld_addr;
            rf_wdata  <= ld_data;
            grant_src <= 1'b1;
        end else begin
            rf_we     <= 1'b0;
        end
    end

`ifdef RF_FWD_EN
    logic live_write;

    assign live_write = rf_we && (rf_waddr != '0);
    assign fwd_hit[0] = live_write && (rf_waddr == rd_addr1);
    assign fwd_hit[1] = live_write && (rf_waddr == rd_addr2);
    assign fwd_hit[2] = live_write && (rf_waddr == rd_addr3);
    assign fwd_data   = rf_wdata;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized check of regfile_write_arbiter against a transaction-level model.
module tb_regfile_write_arbiter;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int MW = 4;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          wb_valid, ld_valid;
    logic [AW-1:0] wb_addr, ld_addr;
    logic [DW-1:0] wb_data, ld_data;
    logic          wb_ready, ld_ready, rf_we, stall, grant_src;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef RF_FWD_EN
    logic [AW-1:0] rd_addr1, rd_addr2, rd_addr3;
    logic [2:0]    fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    always #5 CLK = ~CLK;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .WAIT_W(3)) dut (
        .CLK(CLK), .Reset(Reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall(stall),
`ifdef RF_FWD_EN
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
        .grant_src(grant_src)
    );

    int errors = 0;
    int checks = 0;

    // Model: whether the loader is being forced through, and how many cycles in a row it has been refused.
    bit            m_force;
    int            m_blocked;
    logic          exp_we, exp_src;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    bit            wb_x, ld_x;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_force   = 1'b0;
        m_blocked = 0;
        exp_we    = 1'b0;
        exp_src   = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
    endtask

    // One clock: inputs are already driven; checks handshake outputs, then the registered write port after the edge.
    task automatic cycle();
        bit e_wbr, e_ldr;
        #1;
        e_wbr = !m_force;
        e_ldr = m_force || !wb_valid;
        chk("wb_ready", wb_ready, e_wbr);
        chk("ld_ready", ld_ready, e_ldr);
        chk("stall", stall, m_force);
`ifdef RF_FWD_EN
        begin
            logic [2:0] e_hit;
            e_hit[0] = exp_we && exp_addr != 0 && exp_addr == rd_addr1;
            e_hit[1] = exp_we && exp_addr != 0 && exp_addr == rd_addr2;
            e_hit[2] = exp_we && exp_addr != 0 && exp_addr == rd_addr3;
            chk("fwd_hit", fwd_hit, e_hit);
            chk("fwd_data", fwd_data, exp_data);
        end
`endif
        wb_x = wb_valid && e_wbr;
        ld_x = ld_valid && e_ldr;
        @(posedge CLK);
        #1;
        if (wb_x) begin
            exp_src = 1'b0; exp_addr = wb_addr; exp_data = wb_data;
        end else if (ld_x) begin
            exp_src = 1'b1; exp_addr = ld_addr; exp_data = ld_data;
        end
        exp_we = (wb_x || ld_x) && exp_addr != 0;
        if (m_force) begin
            m_force   = 1'b0;
            m_blocked = 0;
        end else if (ld_valid && !e_ldr) begin
            m_blocked++;
            if (m_blocked == MW) begin
                m_force   = 1'b1;
                m_blocked = 0;
            end
        end else begin
            m_blocked = 0;
        end
        chk("rf_we", rf_we, exp_we);
        chk("rf_waddr", rf_waddr, exp_addr);
        chk("rf_wdata", rf_wdata, exp_data);
        chk("grant_src", grant_src, exp_src);
    endtask

    initial begin
        Reset = 1'b0;
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
`ifdef RF_FWD_EN
        rd_addr1 = 0; rd_addr2 = 0; rd_addr3 = 0;
`endif
        wb_x = 0; ld_x = 0;
        model_reset();
        #1;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_stall", stall, 0);
        chk("reset_grant_src", grant_src, 0);
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;

        // Idle after reset
        #1;
        chk("idle_wb_ready", wb_ready, 1);
        chk("idle_ld_ready", ld_ready, 1);
        chk("idle_rf_we", rf_we, 0);
        cycle();

        // Writeback only
        wb_valid = 1; wb_addr = 3; wb_data = 16'hBEEF;
        cycle();
        wb_valid = 0;
        chk("wb_only_we", rf_we, 1);
        chk("wb_only_addr", rf_waddr, 3);
        chk("wb_only_data", rf_wdata, 16'hBEEF);
        chk("wb_only_src", grant_src, 0);
        cycle();

        // Conflict resolved before starvation threshold
        wb_valid = 1; wb_addr = 1; wb_data = 16'h1111;
        ld_valid = 1; ld_addr = 5; ld_data = 16'h1234;
        cycle();
        wb_data = 16'h2222;
        cycle();
        wb_valid = 0;
        #1 chk("conflict_ld_ready", ld_ready, 1);
        chk("conflict_stall", stall, 0);
        cycle();
        ld_valid = 0;
        chk("conflict_we", rf_we, 1);
        chk("conflict_addr", rf_waddr, 5);
        chk("conflict_data", rf_wdata, 16'h1234);
        chk("conflict_src", grant_src, 1);

        // Starvation forces one loader write
        wb_valid = 1; wb_addr = 4; wb_data = 16'h4444;
        ld_valid = 1; ld_addr = 2; ld_data = 16'h00AA;
        repeat (4) cycle();
        #1 chk("starve_stall", stall, 1);
        chk("starve_wb_ready", wb_ready, 0);
        cycle();
        ld_valid = 0;
        chk("starve_we", rf_we, 1);
        chk("starve_src", grant_src, 1);
        chk("starve_addr", rf_waddr, 2);
        #1 chk("starve_stall_fall", stall, 0);
        chk("starve_wb_ready_back", wb_ready, 1);
        wb_addr = 7; wb_data = 16'h7777;
        cycle();
        wb_valid = 0;

        // Loader write to register 0
        ld_valid = 1; ld_addr = 0; ld_data = 16'h5555;
        #1 chk("r0_ld_ready", ld_ready, 1);
        cycle();
        ld_valid = 0;
        chk("r0_we", rf_we, 0);
        chk("r0_src", grant_src, 1);

        // Reset during FORCE
        wb_valid = 1; wb_addr = 6; wb_data = 16'h6666;
        ld_valid = 1; ld_addr = 3; ld_data = 16'h3333;
        repeat (4) cycle();
        #1 chk("rf_stall_pre", stall, 1);
        chk("rf_we_pre", rf_we, 1);
        Reset = 1'b0;
        #1;
        chk("rst_force_stall", stall, 0);
        chk("rst_force_we", rf_we, 0);
        chk("rst_force_wb_ready", wb_ready, 1);
        model_reset();
        wb_valid = 0; ld_valid = 0;
        #1 Reset = 1'b1;
        @(posedge CLK);
        #1;

`ifdef RF_FWD_EN
        wb_valid = 1; wb_addr = 6; wb_data = 16'hF00D;
        rd_addr1 = 1; rd_addr2 = 6; rd_addr3 = 2;
        cycle();
        wb_valid = 0;
        chk("fwd_literal_hit", fwd_hit, 3'b010);
        chk("fwd_literal_data", fwd_data, 16'hF00D);
        cycle();
`endif

        // Randomized traffic; requests hold until accepted
        wb_x = 0; ld_x = 0;
        for (int n = 0; n < 400; n++) begin
            if (wb_x || !wb_valid) begin
                wb_valid = ($urandom_range(0, 3) != 0);
                wb_addr  = AW'($urandom);
                wb_data  = DW'($urandom);
            end
            if (ld_x || !ld_valid) begin
                ld_valid = ($urandom_range(0, 1) != 0);
                ld_addr  = AW'($urandom);
                ld_data  = DW'($urandom);
            end
`ifdef RF_FWD_EN
            rd_addr1 = AW'($urandom);
            rd_addr2 = AW'($urandom);
            rd_addr3 = AW'($urandom);
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
